// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: movement tick, ball position/direction, paddle collision,
// scoring and the IDLE/SERVE/PLAY/OVER flow. Every output comes straight from a flop.
module pong_game_ctrl #(
    parameter int CLKS_PER_MOVE     = 250000,
    parameter int SERVE_DELAY_MOVES = 120,
    parameter int WIN_SCORE         = 7,
    parameter int BALL_SIZE         = 16,
    parameter int PADDLE_W          = 8,
    parameter int PADDLE_H          = 64,
    parameter int PADDLE_X_L        = 16,
    parameter int PADDLE_X_R        = 616,
    parameter int SCREEN_W          = 640,
    parameter int SCREEN_H          = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] state,
    output logic       point,
    output logic       winner
);

    localparam int TW = (CLKS_PER_MOVE > 1) ? $clog2(CLKS_PER_MOVE) : 1;
    localparam int SW = (SERVE_DELAY_MOVES > 1) ? $clog2(SERVE_DELAY_MOVES) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_MOVE - 1);
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_DELAY_MOVES - 1);
    localparam logic [9:0]    CENTRE_X   = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]    CENTRE_Y   = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
    localparam logic [9:0]    X_MAX      = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]    Y_MAX      = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]    FACE_L_X   = 10'(PADDLE_X_L + PADDLE_W);
    localparam logic [10:0]   FACE_R_X   = 11'(PADDLE_X_R);
    localparam logic [10:0]   BALL_SZ11  = 11'(BALL_SIZE);
    localparam logic [10:0]   PAD_H11    = 11'(PADDLE_H);
    localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // dx_r/dy_r: 1 means +1 (right/down), 0 means -1 (left/up)
    state_t        state_r, state_n;
    logic [TW-1:0] tick_cnt_r;
    logic [SW-1:0] serve_cnt_r, serve_cnt_n;
    logic [9:0]    ball_x_r, ball_x_n;
    logic [9:0]    ball_y_r, ball_y_n;
    logic          dx_r, dx_n;
    logic          dy_r, dy_n;
    logic [3:0]    score_l_r, score_l_n;
    logic [3:0]    score_r_r, score_r_n;
    logic          point_r, point_n;
    logic          winner_r, winner_n;

    logic          tick_s;
    logic          dx_upd_s, dy_upd_s;
    logic          overlap_l_s, overlap_r_s;
    logic          hit_l_s, hit_r_s;
    logic          miss_l_s, miss_r_s;
    logic [3:0]    score_l_inc_s, score_r_inc_s;
    logic [10:0]   ball_y11_s, ball_x11_s;

    assign tick_s = (tick_cnt_r == TICK_LAST);

    // Free-running movement tick divider, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Collision and miss detection from registered position/direction
    always_comb begin
        ball_x11_s    = {1'b0, ball_x_r};
        ball_y11_s    = {1'b0, ball_y_r};
        overlap_l_s   = ((ball_y11_s + BALL_SZ11) > {1'b0, paddle_l_y}) &&
                        (ball_y11_s < ({1'b0, paddle_l_y} + PAD_H11));
        overlap_r_s   = ((ball_y11_s + BALL_SZ11) > {1'b0, paddle_r_y}) &&
                        (ball_y11_s < ({1'b0, paddle_r_y} + PAD_H11));
        hit_l_s       = !dx_r && (ball_x_r == FACE_L_X) && overlap_l_s;
        hit_r_s       = dx_r && ((ball_x11_s + BALL_SZ11) == FACE_R_X) && overlap_r_s;
        miss_l_s      = !dx_r && (ball_x_r == 10'd0);
        miss_r_s      = dx_r && (ball_x_r == X_MAX);
        score_l_inc_s = score_l_r + 4'd1;
        score_r_inc_s = score_r_r + 4'd1;

        if (ball_y_r == 10'd0) begin
            dy_upd_s = 1'b1;
        end else if (ball_y_r == Y_MAX) begin
            dy_upd_s = 1'b0;
        end else begin
            dy_upd_s = dy_r;
        end

        if (hit_l_s) begin
            dx_upd_s = 1'b1;
        end else if (hit_r_s) begin
            dx_upd_s = 1'b0;
        end else begin
            dx_upd_s = dx_r;
        end
    end

    // Game flow next-state and datapath updates
    always_comb begin
        state_n     = state_r;
        serve_cnt_n = serve_cnt_r;
        ball_x_n    = ball_x_r;
        ball_y_n    = ball_y_r;
        dx_n        = dx_r;
        dy_n        = dy_r;
        score_l_n   = score_l_r;
        score_r_n   = score_r_r;
        point_n     = 1'b0;
        winner_n    = winner_r;

        case (state_r)
            ST_IDLE: begin
                score_l_n   = 4'd0;
                score_r_n   = 4'd0;
                ball_x_n    = CENTRE_X;
                ball_y_n    = CENTRE_Y;
                serve_cnt_n = {SW{1'b0}};
                if (start) begin
                    state_n = ST_SERVE;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_SERVE: begin
                ball_x_n = CENTRE_X;
                ball_y_n = CENTRE_Y;
                if (tick_s && (serve_cnt_r == SERVE_LAST)) begin
                    state_n     = ST_PLAY;
                    serve_cnt_n = {SW{1'b0}};
                end else if (tick_s) begin
                    serve_cnt_n = serve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    serve_cnt_n = serve_cnt_r;
                end
            end

            ST_PLAY: begin
                if (tick_s && miss_l_s) begin
                    score_r_n = score_r_inc_s;
                    point_n   = 1'b1;
                    if (score_r_inc_s == WIN_VAL) begin
                        state_n  = ST_OVER;
                        winner_n = 1'b1;
                    end else begin
                        state_n     = ST_SERVE;
                        ball_x_n    = CENTRE_X;
                        ball_y_n    = CENTRE_Y;
                        serve_cnt_n = {SW{1'b0}};
                        dx_n        = 1'b0;
                        dy_n        = 1'b0;
                    end
                end else if (tick_s && miss_r_s) begin
                    score_l_n = score_l_inc_s;
                    point_n   = 1'b1;
                    if (score_l_inc_s == WIN_VAL) begin
                        state_n  = ST_OVER;
                        winner_n = 1'b0;
                    end else begin
                        state_n     = ST_SERVE;
                        ball_x_n    = CENTRE_X;
                        ball_y_n    = CENTRE_Y;
                        serve_cnt_n = {SW{1'b0}};
                        dx_n        = 1'b1;
                        dy_n        = 1'b0;
                    end
                end else if (tick_s) begin
                    // Reversal is applied before the step, so the edges never wrap
                    dx_n     = dx_upd_s;
                    dy_n     = dy_upd_s;
                    ball_x_n = dx_upd_s ? (ball_x_r + 10'd1) : (ball_x_r - 10'd1);
                    ball_y_n = dy_upd_s ? (ball_y_r + 10'd1) : (ball_y_r - 10'd1);
                end else begin
                    state_n = ST_PLAY;
                end
            end

            ST_OVER: begin
                if (start) begin
                    state_n     = ST_SERVE;
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    ball_x_n    = CENTRE_X;
                    ball_y_n    = CENTRE_Y;
                    serve_cnt_n = {SW{1'b0}};
                    dx_n        = 1'b1;
                    dy_n        = 1'b0;
                end else begin
                    state_n = ST_OVER;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Game state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            serve_cnt_r <= {SW{1'b0}};
            ball_x_r    <= CENTRE_X;
            ball_y_r    <= CENTRE_Y;
            dx_r        <= 1'b1;
            dy_r        <= 1'b0;
            score_l_r   <= 4'd0;
            score_r_r   <= 4'd0;
            point_r     <= 1'b0;
            winner_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            serve_cnt_r <= serve_cnt_n;
            ball_x_r    <= ball_x_n;
            ball_y_r    <= ball_y_n;
            dx_r        <= dx_n;
            dy_r        <= dy_n;
            score_l_r   <= score_l_n;
            score_r_r   <= score_r_n;
            point_r     <= point_n;
            winner_r    <= winner_n;
        end
    end

    assign ball_x  = ball_x_r;
    assign ball_y  = ball_y_r;
    assign score_l = score_l_r;
    assign score_r = score_r_r;
    assign state   = state_r;
    assign point   = point_r;
    assign winner  = winner_r;

endmodule
